// File: rtl/updown_chk_pkg.sv
// -----------------------------------------------------------------------------
// updown_chk_pkg
//
// Shared definitions for the up/down counter checker:
//   - chk_state_t      : checker FSM states (IDLE, SYNC, TRACK, LOCK)
//   - ERR_CNT_MAX      : saturation value of the mismatch counter
//   - DEFAULT_WIDTH    : default width of the observed count bus
//   - DEFAULT_LOCK_CNT : default number of consecutive good steps to lock
// -----------------------------------------------------------------------------
package updown_chk_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,   // held in reset
        SYNC  = 2'd1,   // capturing a fresh reference, no check
        TRACK = 2'd2,   // checking, not yet locked
        LOCK  = 2'd3    // checking, locked
    } chk_state_t;

    localparam int ERR_CNT_MAX      = 255;
    localparam int DEFAULT_WIDTH    = 8;
    localparam int DEFAULT_LOCK_CNT = 4;

endpackage : updown_chk_pkg

// File: rtl/updown_chk_satcnt.sv
// -----------------------------------------------------------------------------
// updown_chk_satcnt
//
// 8-bit saturating incrementer with synchronous clear. Holds at ERR_CNT_MAX
// once reached; clear has priority over increment.
//
// Ports:
//   clk  in   clock
//   clr  in   synchronous clear (active high)
//   inc  in   increment request for this cycle
//   cnt  out  current count value
// -----------------------------------------------------------------------------
module updown_chk_satcnt
    import updown_chk_pkg::*;
(
    input  logic       clk,
    input  logic       clr,
    input  logic       inc,
    output logic [7:0] cnt
);

    localparam logic [7:0] CNT_MAX = 8'(ERR_CNT_MAX);

    logic [7:0] cnt_reg;
    logic [7:0] cnt_next;

    always_comb begin
        cnt_next = cnt_reg;
        if (inc && (cnt_reg != CNT_MAX)) begin
            cnt_next = cnt_reg + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

    assign cnt = cnt_reg;

endmodule : updown_chk_satcnt

// File: rtl/updown_count_checker.sv
// -----------------------------------------------------------------------------
// updown_count_checker
//
// Passive monitor for an up/down counter. Each cycle it remembers the observed
// count and direction; from the third posedge after reset release it checks
// that the new count equals the previous count stepped by one in the previous
// direction (modulo 2^WIDTH). A mismatch flags err, bumps err_count and
// forces a one-cycle resynchronisation. LOCK_CNT consecutive good steps
// assert locked. Wrap-around steps produce one-cycle wrap pulses.
//
// Parameters:
//   WIDTH     width of the observed count bus
//   LOCK_CNT  consecutive good steps needed before locked asserts (>= 1)
//
// Ports:
//   clk        in   clock
//   rst        in   synchronous reset, active high
//   mode       in   direction of the observed counter (1 = down, 0 = up)
//   count      in   observed counter value
//   err        out  mismatch flag (registered, one-cycle pulse by default)
//   err_count  out  mismatches since reset, saturating at 255
//   wrap_up    out  pulse after a good MAX -> 0 step while counting up
//   wrap_down  out  pulse after a good 0 -> MAX step while counting down
//   locked     out  high while LOCK_CNT or more consecutive good steps seen
//
// Build option:
//   UPDOWN_CHK_STICKY_ERR_EN  when defined, err stays high from the first
//                             mismatch until reset.
// -----------------------------------------------------------------------------
module updown_count_checker #(
    parameter int WIDTH    = updown_chk_pkg::DEFAULT_WIDTH,
    parameter int LOCK_CNT = updown_chk_pkg::DEFAULT_LOCK_CNT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mode,
    input  logic [WIDTH-1:0] count,
    output logic             err,
    output logic [7:0]       err_count,
    output logic             wrap_up,
    output logic             wrap_down,
    output logic             locked
);

    import updown_chk_pkg::*;

    // Good-step counter only needs to reach LOCK_CNT.
    localparam int                GOOD_W    = (LOCK_CNT < 1) ? 1 : $clog2(LOCK_CNT + 1);
    localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(LOCK_CNT - 1);
    localparam logic [GOOD_W-1:0] GOOD_ONE  = GOOD_W'(1);
    localparam logic [WIDTH-1:0]  CNT_ONE   = WIDTH'(1);
    localparam logic [WIDTH-1:0]  CNT_MAX   = {WIDTH{1'b1}};

    chk_state_t        state_reg;
    chk_state_t        state_next;

    logic [WIDTH-1:0]  prev_count_reg;
    logic              prev_mode_reg;
    logic [GOOD_W-1:0] good_reg;
    logic [GOOD_W-1:0] good_next;
    logic              err_reg;
    logic              err_next;
    logic              wrap_up_reg;
    logic              wrap_up_next;
    logic              wrap_down_reg;
    logic              wrap_down_next;
    logic              locked_reg;
    logic              locked_next;

    logic [WIDTH-1:0]  expected;
    logic              check_en;
    logic              step_ok;
    logic              step_bad;
    logic              err_inc;

    // -------------------------------------------------------------------------
    // Step comparison: the previous direction decides the expected value, so a
    // direction change is honoured on the very next step.
    // -------------------------------------------------------------------------
    always_comb begin
        expected = prev_mode_reg ? (prev_count_reg - CNT_ONE)
                                 : (prev_count_reg + CNT_ONE);
        check_en = (state_reg == TRACK) || (state_reg == LOCK);
        step_ok  = check_en && (count == expected);
        step_bad = check_en && (count != expected);
    end

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:  state_next = SYNC;
            SYNC:  state_next = TRACK;
            TRACK: begin
                if (step_bad) begin
                    state_next = SYNC;
                end else if (step_ok && (good_reg == GOOD_LAST)) begin
                    state_next = LOCK;
                end
            end
            LOCK: begin
                if (step_bad) begin
                    state_next = SYNC;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: output logic (next values of the registered outputs)
    // -------------------------------------------------------------------------
    always_comb begin
        good_next      = good_reg;
        locked_next    = locked_reg;
        wrap_up_next   = 1'b0;
        wrap_down_next = 1'b0;
        err_inc        = step_bad;
`ifdef UPDOWN_CHK_STICKY_ERR_EN
        err_next       = err_reg | step_bad;
`else
        err_next       = step_bad;
`endif
        if (step_bad) begin
            good_next   = '0;
            locked_next = 1'b0;
        end else if (step_ok) begin
            // Good steps only accumulate until lock; in LOCK the count holds.
            if (state_reg == TRACK) begin
                good_next = good_reg + GOOD_ONE;
                if (good_reg == GOOD_LAST) begin
                    locked_next = 1'b1;
                end
            end
            // Wraps are reported only for steps that matched.
            wrap_up_next   = !prev_mode_reg && (prev_count_reg == CNT_MAX);
            wrap_down_next =  prev_mode_reg && (prev_count_reg == '0);
        end
    end

    // -------------------------------------------------------------------------
    // Datapath and registered outputs
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_count_reg <= '0;
            prev_mode_reg  <= 1'b0;
            good_reg       <= '0;
            err_reg        <= 1'b0;
            wrap_up_reg    <= 1'b0;
            wrap_down_reg  <= 1'b0;
            locked_reg     <= 1'b0;
        end else begin
            prev_count_reg <= count;
            prev_mode_reg  <= mode;
            good_reg       <= good_next;
            err_reg        <= err_next;
            wrap_up_reg    <= wrap_up_next;
            wrap_down_reg  <= wrap_down_next;
            locked_reg     <= locked_next;
        end
    end

    updown_chk_satcnt u_err_cnt (
        .clk (clk),
        .clr (rst),
        .inc (err_inc),
        .cnt (err_count)
    );

    assign err       = err_reg;
    assign wrap_up   = wrap_up_reg;
    assign wrap_down = wrap_down_reg;
    assign locked    = locked_reg;

endmodule : updown_count_checker
